// File: rtl/keysw_io_pkg.sv
// keysw_io_dev_pkg: shared register map, bit positions and pin-group widths for keysw_io_dev
package keysw_io_dev_pkg;
  localparam int KEYBITS = 4;
  localparam int SWBITS = 10;
  localparam logic [31:0] ADDRKEY = 32'hFFFFF080;
  localparam logic [31:0] ADDRSW = 32'hFFFFF090;
  localparam logic [31:0] OFF_DATA = 32'd0;
  localparam logic [31:0] OFF_CTRL = 32'd4;
  localparam int READY = 0;
  localparam int OVR = 2;
  localparam int IE = 4;
  function automatic logic [4:0] ctrl_word(input logic ready, input logic ovr, input logic ie);
    ctrl_word = '0;
    ctrl_word[READY] = ready;
    ctrl_word[OVR] = ovr;
    ctrl_word[IE] = ie;
  endfunction
endpackage

// File: rtl/keysw_io_dev_input_debouncer.sv
// input_debouncer: 2-flop synchronizer plus persistence-count debouncer for one pin group
// Ports: clk, reset (async, active-high), pins (raw), stable (debounced, active level),
//        chg (high in the cycle whose closing edge updates stable).
// stable is kept relative to IDLE (pins ^ IDLE), so active-low groups read as 1 when asserted.
module input_debouncer #(
  parameter int WIDTH = 1,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter logic [WIDTH-1:0] IDLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] stable,
  output logic             chg
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [WIDTH-1:0] s1, s2, level;
  logic [CW-1:0] cnt;
  logic differs;
  assign level = s2 ^ IDLE;
  assign differs = level != stable;
  // chg is combinational so the flags in the parent update on the same edge as stable
  assign chg = differs && cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= IDLE;
      s2 <= IDLE;
      stable <= '0;
      cnt <= '0;
    end else begin
      s1 <= pins;
      s2 <= s1;
      stable <= chg ? level : stable;
      cnt <= (!differs || chg) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/keysw_io_dev.sv
// keysw_io_dev: memory-mapped KEY/SW input device with debounce, ready/overrun flags
// Ports: clk, reset (async, active-high), KEY (active-low), SW, addr/rd_en/wr_en/wdata (MEM-stage
//        bus), sel/rdata (combinational read path), irq (only when KEYSW_IRQ_EN is defined).
// Map: ADDRKEY KDATA, ADDRKEY+4 KCTRL, ADDRSW SDATA, ADDRSW+4 SCTRL; CTRL = {IE[4], OVR[2], READY[0]}.
// Macro KEYSW_IRQ_EN: adds irq output and read/write IE bits; otherwise IE reads 0.
module keysw_io_dev import keysw_io_dev_pkg::*; #(
  parameter int DBITS = 32,
  parameter int KEYBITS = keysw_io_dev_pkg::KEYBITS,
  parameter int SWBITS = keysw_io_dev_pkg::SWBITS,
  parameter logic [DBITS-1:0] ADDRKEY = keysw_io_dev_pkg::ADDRKEY,
  parameter logic [DBITS-1:0] ADDRSW = keysw_io_dev_pkg::ADDRSW,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEYBITS-1:0] KEY,
  input  logic [SWBITS-1:0]  SW,
  input  logic [DBITS-1:0]   addr,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [DBITS-1:0]   wdata,
  output logic               sel,
  output logic [DBITS-1:0]   rdata
`ifdef KEYSW_IRQ_EN
  ,
  output logic               irq
`endif
);
  logic [KEYBITS-1:0] key_stable;
  logic [SWBITS-1:0] sw_stable;
  // index 0 = key device, index 1 = switch device
  logic [1:0] chg, hit_data, hit_ctrl, rd_data, wr_ctrl, ready, ready_n, ovr, ie;
  input_debouncer #(.WIDTH(KEYBITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE({KEYBITS{1'b1}})) u_key (
    .clk(clk), .reset(reset), .pins(KEY), .stable(key_stable), .chg(chg[0])
  );
  input_debouncer #(.WIDTH(SWBITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE('0)) u_sw (
    .clk(clk), .reset(reset), .pins(SW), .stable(sw_stable), .chg(chg[1])
  );
  assign hit_data = {addr == ADDRSW + DBITS'(OFF_DATA), addr == ADDRKEY + DBITS'(OFF_DATA)};
  assign hit_ctrl = {addr == ADDRSW + DBITS'(OFF_CTRL), addr == ADDRKEY + DBITS'(OFF_CTRL)};
  assign sel = |{hit_data, hit_ctrl};
  // a simultaneous load and store is a store: no read side effect
  assign rd_data = hit_data & {2{rd_en & ~wr_en}};
  assign wr_ctrl = hit_ctrl & {2{wr_en}};
  // a change coinciding with a DATA read keeps ready: the read consumed the previous value
  assign ready_n = chg | (ready & ~rd_data);
  assign rdata = hit_data[0] ? DBITS'(key_stable) :
                 hit_data[1] ? DBITS'(sw_stable) :
                 hit_ctrl[0] ? DBITS'(ctrl_word(ready[0], ovr[0], ie[0])) :
                 hit_ctrl[1] ? DBITS'(ctrl_word(ready[1], ovr[1], ie[1])) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ready <= '0;
      ovr <= '0;
    end else begin
      ready <= ready_n;
      ovr <= (chg & ready & ~rd_data) | (ovr & ~(wr_ctrl & {2{~wdata[OVR]}}));
    end
`ifdef KEYSW_IRQ_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ie <= '0;
      irq <= 1'b0;
    end else begin
      ie <= (wr_ctrl & {2{wdata[IE]}}) | (ie & ~wr_ctrl);
      irq <= |(((wr_ctrl & {2{wdata[IE]}}) | (ie & ~wr_ctrl)) & ready_n);
    end
`else
  assign ie = '0;
`endif
endmodule

// File: tb/tb_keysw_io_dev.sv
// tb_keysw_io_dev: directed plus randomized check of keysw_io_dev against a behavioural model
module tb_keysw_io_dev;
  localparam int DC = 4;
  localparam logic [31:0] KD = 32'hFFFFF080;
  localparam logic [31:0] KC = 32'hFFFFF084;
  localparam logic [31:0] SD = 32'hFFFFF090;
  localparam logic [31:0] SC = 32'hFFFFF094;
  logic clk = 0;
  logic reset;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [31:0] addr, wdata, rdata;
  logic rd_en, wr_en, sel;
`ifdef KEYSW_IRQ_EN
  logic irq;
`endif
  int n_checks = 0;
  int n_pass = 0;
  keysw_io_dev #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .KEY(KEY), .SW(SW), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wdata(wdata), .sel(sel), .rdata(rdata)
`ifdef KEYSW_IRQ_EN
    , .irq(irq)
`endif
  );
  always #5 clk = ~clk;
  // reference model: per device, active-level pin history, run of differing samples, flags
  logic [9:0] m_d1[2], m_d2[2], m_stable[2];
  int m_run[2];
  bit m_ready[2], m_ovr[2], m_ie[2], m_irq;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_d1[d] = '0; m_d2[d] = '0; m_stable[d] = '0; m_run[d] = 0;
      m_ready[d] = 0; m_ovr[d] = 0; m_ie[d] = 0;
    end
    m_irq = 0;
  endfunction
  function automatic logic [31:0] base(input int d);
    return d == 0 ? KD : SD;
  endfunction
  function automatic bit is_reg(input logic [31:0] a);
    return a == KD || a == KC || a == SD || a == SC;
  endfunction
  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    for (int d = 0; d < 2; d++) begin
      if (a == base(d)) return 32'(m_stable[d]);
      if (a == base(d) + 4) return 32'(m_ready[d]) + 4 * 32'(m_ovr[d]) + 16 * 32'(m_ie[d]);
    end
    return 0;
  endfunction
  function automatic void model_edge(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd);
    logic [9:0] pin[2];
    logic [9:0] sync;
    bit chg, rdd, wc;
    pin[0] = {6'b0, ~KEY};
    pin[1] = SW;
    for (int d = 0; d < 2; d++) begin
      sync = m_d2[d];
      m_d2[d] = m_d1[d];
      m_d1[d] = pin[d];
      chg = 0;
      if (sync != m_stable[d]) begin
        m_run[d]++;
        if (m_run[d] == DC) begin
          chg = 1; m_stable[d] = sync; m_run[d] = 0;
        end
      end else m_run[d] = 0;
      rdd = rd && !wr && a == base(d);
      wc = wr && a == base(d) + 4;
      if (chg && m_ready[d] && !rdd) m_ovr[d] = 1;
      else if (wc && !wd[2]) m_ovr[d] = 0;
      m_ready[d] = chg || (m_ready[d] && !rdd);
`ifdef KEYSW_IRQ_EN
      if (wc) m_ie[d] = wd[4];
`endif
    end
    m_irq = (m_ie[0] && m_ready[0]) || (m_ie[1] && m_ready[1]);
  endfunction
  task automatic cycle(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd);
    addr = a; rd_en = rd; wr_en = wr; wdata = wd;
    #1;
    check("sel", 32'(sel), 32'(is_reg(a)));
    check("rdata", rdata, exp_rdata(a));
`ifdef KEYSW_IRQ_EN
    check("irq", 32'(irq), 32'(m_irq));
`endif
    @(posedge clk);
    model_edge(a, rd, wr, wd);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) cycle(32'h0, 1'b0, 1'b0, 32'h0);
  endtask
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; rd_en = 0; wr_en = 0;
    #1;
    check({tag, "_sel"}, 32'(sel), 32'(is_reg(a)));
    check(tag, rdata, exp);
  endtask
  task automatic do_reset();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    KEY = '1; SW = '0; addr = '0; rd_en = 0; wr_en = 0; wdata = '0;
    do_reset();
`ifdef KEYSW_IRQ_EN
    check("irq_reset", 32'(irq), 32'h0);
`endif
    peek("kdata_reset", KD, 0);
    peek("kctrl_reset", KC, 0);
    peek("sdata_reset", SD, 0);
    idle(1);
    peek("sctrl_reset", SC, 0);
    KEY = 4'b1110;
    for (int i = 1; i <= 6; i++) begin
      cycle(32'h0, 1'b0, 1'b0, 32'h0);
      peek("kdata_latency", KD, i == 6 ? 32'h1 : 32'h0);
    end
    peek("kctrl_ready", KC, 1);
    cycle(KD, 1'b1, 1'b0, 32'h0);
    peek("kctrl_after_read", KC, 0);
    SW = 10'h008;
    for (int i = 0; i < 3; i++) begin
      cycle(32'h0, 1'b0, 1'b0, 32'h0);
      peek("sdata_glitch", SD, 0);
    end
    SW = 10'h000;
    for (int i = 0; i < 2; i++) begin
      cycle(32'h0, 1'b0, 1'b0, 32'h0);
      peek("sdata_glitch_restore", SD, 0);
      peek("sctrl_glitch_restore", SC, 0);
    end
    SW = 10'h008;
    for (int i = 1; i <= 6; i++) begin
      cycle(32'h0, 1'b0, 1'b0, 32'h0);
      peek("sdata_hold", SD, i == 6 ? 32'h8 : 32'h0);
      peek("sctrl_hold", SC, i == 6 ? 32'h1 : 32'h0);
    end
    idle(6);
    peek("sctrl_single_pulse", SC, 1);
    SW = 10'h00C;
    idle(6);
    peek("sdata_second", SD, 32'hC);
    peek("sctrl_overrun", SC, 5);
    cycle(SC, 1'b0, 1'b1, 32'h0);
    peek("sctrl_ovr_cleared", SC, 1);
    SW = 10'h004;
    idle(5);
    cycle(SD, 1'b1, 1'b0, 32'h0);
    peek("sctrl_read_on_chg", SC, 1);
    peek("sdata_read_on_chg", SD, 4);
    cycle(KC, 1'b0, 1'b1, 32'd16);
`ifdef KEYSW_IRQ_EN
    peek("kctrl_ie", KC, 16);
`else
    peek("kctrl_ie", KC, 0);
`endif
    KEY = 4'b1100;
    for (int i = 1; i <= 6; i++) begin
      cycle(32'h0, 1'b0, 1'b0, 32'h0);
`ifdef KEYSW_IRQ_EN
      check("irq_on_ready", 32'(irq), i == 6 ? 32'h1 : 32'h0);
`endif
    end
    peek("kdata_two_keys", KD, 3);
`ifdef KEYSW_IRQ_EN
    peek("kctrl_ready_ie", KC, 17);
`else
    peek("kctrl_ready_ie", KC, 1);
`endif
    cycle(KD, 1'b1, 1'b0, 32'h0);
`ifdef KEYSW_IRQ_EN
    check("irq_after_read", 32'(irq), 32'h0);
`endif
    peek("unmapped", 32'hFFFFF088, 0);
    KEY = '1;
    SW = 10'h3FF;
    idle(3);
    reset = 1;
    model_reset();
    peek("kctrl_mid_reset", KC, 0);
    peek("sctrl_mid_reset", SC, 0);
    SW = 10'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    idle(8);
    peek("sdata_no_late", SD, 0);
    peek("sctrl_no_late", SC, 0);
    SW = 10'h155;
    do_reset();
    idle(6);
    peek("sdata_on_at_reset", SD, 32'h155);
    peek("sctrl_on_at_reset", SC, 1);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      int pick;
      if ($urandom_range(7) == 0) KEY = 4'($urandom);
      if ($urandom_range(9) == 0) SW = 10'($urandom);
      pick = $urandom_range(5);
      a = pick == 0 ? KD : pick == 1 ? KC : pick == 2 ? SD : pick == 3 ? SC :
          pick == 4 ? 32'hFFFFF088 : $urandom;
      cycle(a, 1'($urandom), $urandom_range(3) == 0, $urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/keysw_io_dev.md
Name: keysw_io_dev

Overview:
- Memory-mapped input device for the KEY and SW pins. Sits downstream of the processor MEM stage on its load/store path.
- Synchronizes and debounces the raw pins, and latches a change-detect ready flag and an overrun flag per device.
- The MEM stage reads it combinationally in the same cycle as the access. Read side effects commit at the next clock edge.

Parameters:
- DBITS, 32, data/address width of the MEM-stage bus.
- KEYBITS, 4, number of KEY pins.
- SWBITS, 10, number of SW pins.
- ADDRKEY, 32'hFFFFF080, KDATA address; KCTRL is at ADDRKEY+4.
- ADDRSW, 32'hFFFFF090, SDATA address; SCTRL is at ADDRSW+4.
- DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronized change must persist before acceptance; must be >=2.

Ports:
- clk  in  1  processor clock.
- reset  in  1  asynchronous, active-high.
- KEY  in  KEYBITS  raw push-buttons, active-low.
- SW  in  SWBITS  raw slide switches, active-high.
- addr  in  DBITS  MEM-stage address (the ALU output).
- rd_en  in  1  MEM stage is executing a load.
- wr_en  in  1  MEM stage is executing a store.
- wdata  in  DBITS  store data.
- sel  out  1  addr matches one of the four device registers (combinational).
- rdata  out  DBITS  read data (combinational); zero when sel=0.
- irq  out  1  interrupt request; present only under KEYSW_IRQ_EN.

Behaviour:
- Register map. Reads of unused bits return 0.
  - KDATA: bits [KEYBITS-1:0] hold debounced ~KEY, so a pressed key reads as 1.
  - KCTRL: bit0 = ready, bit2 = overrun, bit4 = IE.
  - SDATA: bits [SWBITS-1:0] hold debounced SW.
  - SCTRL: same layout as KCTRL.
- Input path, per pin group:
  - 2-flop synchronizer.
  - Debouncer holds `stable` and a counter `cnt`.
  - If sync != stable: cnt increments. When cnt == DEBOUNCE_CYCLES-1 and sync still differs, stable <= sync and cnt <= 0.
  - If sync == stable: cnt <= 0. Any mid-count bounce restarts the count.
  - Latency from a clean pin edge to the stable update is 2 + DEBOUNCE_CYCLES clock edges.
  - The debouncer emits a 1-cycle `chg` pulse on the edge where stable updates.
- Flags, per device:
  - chg sets ready.
  - chg while ready=1 (and not cleared this cycle) also sets overrun.
  - rd_en to the DATA address clears ready at the next posedge.
  - chg and a DATA read in the same cycle: ready stays 1 and overrun is unchanged, because the read consumed the old value.
- CTRL writes:
  - ready is read-only.
  - Writing bit2=0 clears overrun. Writing bit2=1 leaves it unchanged.
  - bit4 writes IE.
- Other accesses:
  - Writes to DATA addresses are ignored.
  - rd_en and wr_en both high: treat as a write. No read side effect.
  - Reads of CTRL have no side effect.
- Reset values (asynchronous):
  - Synchronizer flops load the idle pin levels: 1s for KEY, 0s for SW.
  - Key stable = 0, SW stable = 0, cnt = 0.
  - ready, overrun and IE = 0. irq = 0.
  - sel and rdata follow their inputs combinationally.
- Switches that are already on at reset are reported as one change once the debounce completes. This sets SCTRL.ready.
- Reset asserted mid-debounce discards the count.

Optional Feature:
- Macro: KEYSW_IRQ_EN.
- Defined:
  - irq port exists.
  - irq = registered OR over both devices of (IE & ready); it updates on the same edge as the flags.
  - IE bits are read/write.
- Undefined:
  - No irq port.
  - IE bits read as 0 and writes to them are ignored.

Decomposition:
- Shared package: address constants ADDRKEY/ADDRSW and the offsets DATA=0, CTRL=4; CTRL bit positions READY=0, OVR=2, IE=4; KEYBITS and SWBITS.
- One sub-module, `input_debouncer`:
  - Parameters: WIDTH, DEBOUNCE_CYCLES, IDLE.
  - Contents: synchronizer, counter and stable register; outputs `stable` and `chg`.
  - Instantiated twice.
- Flags and decode live in the top module.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset, then read all four registers with KEY=4'hF, SW=0 -> KDATA=0, KCTRL=0, SDATA=0, SCTRL=0, sel=1 for each, irq=0.
- Drive KEY=4'b1110 cleanly -> KDATA=1 and KCTRL=1 exactly 6 edges later; the following read of ADDRKEY returns 1 and KCTRL reads 0 on the next cycle.
- Toggle SW[3] for 3 cycles, restore it, then hold SW=10'h008 -> no update during the glitch; SDATA=8 only 6 edges after the hold starts; a single ready pulse.
- With SCTRL.ready=1 and no read, change SW to 10'h00C -> SCTRL reads 5 (ready+overrun); store 0 to ADDRSW+4 -> reads 1. Then change SW with the SDATA read landing on the chg edge -> ready=1, overrun=0.
- Under KEYSW_IRQ_EN: store 16 to KCTRL, press a key -> irq=1 on the ready edge; read KDATA -> irq=0 the next cycle.
- Read 32'hFFFFF088 -> sel=0, rdata=0. Assert reset mid-debounce -> flags clear and no late update occurs.
